// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types and constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 5;

    // Operation select, encoded exactly as Funct3
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_QUOT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MINUS_ONE = {XLEN{1'b1}};
    localparam logic [CNTW-1:0] CNT_LAST  = {CNTW{1'b1}};

    // Magnitude of a value that may be a negative two's-complement number
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? ((~v) + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply,
// restoring shift-subtract divide, one shared 64-bit working register.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic              res_neg;
    logic [XLEN-1:0]   opnd_q;     // multiplicand for MUL*, divisor for DIV*
    logic [2*XLEN-1:0] work_q;     // {hi, lo} product or {rem, quot}
    logic [CNTW-1:0]   cnt_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, start_neg;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh, diff;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fix_val;

    // Launch-time operand decode: signedness, magnitudes, special cases
    always_comb begin
        a_signed  = (Funct3 != OP_MULHU) && (Funct3 != OP_DIVU) && (Funct3 != OP_REMU);
        b_signed  = (Funct3 == OP_MUL) || (Funct3 == OP_MULH) ||
                    (Funct3 == OP_DIV) || (Funct3 == OP_REM);
        a_neg     = a_signed & SrcA[XLEN-1];
        b_neg     = b_signed & SrcB[XLEN-1];
        a_mag     = mag(SrcA, a_neg);
        b_mag     = mag(SrcB, b_neg);
        div_zero  = Funct3[2] && (SrcB == '0);
        div_ovf   = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                    (SrcA == INT_MIN) && (SrcB == MINUS_ONE);
        // REM takes the dividend sign; everything else the product/quotient sign
        start_neg = (Funct3 == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration of multiply and of divide on the working register
    always_comb begin
        mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_next = work_q[0] ? {mul_sum, work_q[XLEN-1:1]}
                             : {1'b0, work_q[2*XLEN-1:1]};
        rem_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        diff     = rem_sh - {1'b0, opnd_q};
        div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   work_q[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and output word selection
    always_comb begin
        prod = res_neg ? ((~work_q) + (2*XLEN)'(1)) : work_q;
        quot = mag(work_q[XLEN-1:0], res_neg);
        rem  = mag(work_q[2*XLEN-1:XLEN], res_neg);
        unique case (op_q)
            OP_MUL:                      fix_val = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val = quot;
            default:                     fix_val = rem;
        endcase
    end

    // Control FSM with registered outputs and datapath state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_MUL;
            res_neg <= 1'b0;
            opnd_q  <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Result  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        op_q  <= muldiv_op_e'(Funct3);
                        cnt_q <= '0;
                        Busy  <= 1'b1;
                        if (div_zero) begin
                            work_q  <= {SrcA, DIV0_QUOT};
                            res_neg <= 1'b0;
                            state   <= FIX;
                        end else if (div_ovf) begin
                            work_q  <= {{XLEN{1'b0}}, OVF_QUOT};
                            res_neg <= 1'b0;
                            state   <= FIX;
                        end else begin
                            work_q  <= {{XLEN{1'b0}}, Funct3[2] ? a_mag : b_mag};
                            opnd_q  <= Funct3[2] ? b_mag : a_mag;
                            res_neg <= start_neg;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    work_q <= op_q[2] ? div_next : mul_next;
                    cnt_q  <= cnt_q + CNTW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result <= fix_val;
                    Busy   <= 1'b0;
                    Done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, control
// sequences and randomized operations against an arithmetic reference.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int passed = 0;
    int total  = 0;

    localparam int LAT_NORM = 33;
    localparam int LAT_FAST = 1;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // RV32M semantics straight from the ISA rules, using 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'd0, a};
        zb = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * zb; return p[63:32]; end
            3'b011: begin p = za * zb; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return LAT_FAST;
        if ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return LAT_FAST;
        return LAT_NORM;
    endfunction

    // Launch one operation, scramble inputs after E0, check timing and result
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit hold_start);
        int n;
        bit busy_ok;
        @(negedge clk);
        Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) Start = 1'b0;
        Funct3 = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
        n = 0;
        busy_ok = 1'b1;
        while (!Done && n < 60) begin
            if (!Busy || Done) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({name, " busy"}, 32'(busy_ok), 32'd1);
        check({name, " lat"}, 32'(n), 32'(lat));
        check({name, " result"}, Result, exp);
        check({name, " busy_at_done"}, 32'(Busy), 32'd0);
        Start = 1'b0;
        @(posedge clk); #1;
        check({name, " idle_after"}, {30'd0, Busy, Done}, 32'd0);
    endtask

    initial begin
        Start = 1'b0; Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        check("reset result", Result, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_NORM};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_NORM};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORM};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_NORM};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_NORM};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_NORM};
        vecs[6]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_FAST};
        vecs[7]  = '{3'b111, 32'd5,        32'd0,        32'd5,        LAT_FAST};
        vecs[8]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST};
        vecs[9]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_FAST};
        vecs[10] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_FAST};
        vecs[11] = '{3'b101, 32'hFFFFFFFF, 32'd7,        32'h24924924, LAT_NORM};

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].lat, 1'b0);
        end

        // Start held high through CALC and DONE must not relaunch or queue
        run_op("hold_start", 3'b011, 32'h12345678, 32'h9ABCDEF0,
               ref_model(3'b011, 32'h12345678, 32'h9ABCDEF0), LAT_NORM, 1'b1);

        // Asynchronous reset mid-CALC clears everything without a clock edge
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'h12345678; SrcB = 32'd3; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort done", 32'(Done), 32'd0);
        check("abort result", Result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort quiet", {30'd0, Busy, Done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset_mul", 3'b000, 32'd3, 32'd4, 32'd12, LAT_NORM, 1'b0);

        // Randomized operations with a bias toward special-case divisors
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_model(f, a, b),
                   ref_lat(f, a, b), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the multi-cycle core. It sits directly downstream of the register file: it consumes the two latched source operands (ReadData1/ReadData2 via the A/B registers) and returns a 32-bit result. The multi-cycle controller writes that result back through the register file's WriteData port when `Done` is asserted. Multiply uses a radix-2 shift-add datapath and divide uses a restoring shift-subtract datapath; the two share one 64-bit working register.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  launches an operation; sampled only in IDLE.
- `Funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  XLEN  rs1 operand (dividend / multiplicand).
- `SrcB`  in  XLEN  rs2 operand (divisor / multiplier).
- `Busy`  out  1  high in CALC and FIX.
- `Done`  out  1  one-cycle pulse; high only in state DONE.
- `Result`  out  XLEN  registered result.

## Operation
- The clock is `clk`. Reset is asynchronous and active-low on `rst_n`.
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - `Start`=1 latches `Funct3`, `SrcA` and `SrcB`. After that edge, input changes have no effect.
  - It also clears the 5-bit iteration counter.
  - Next state is CALC, or FIX if a special case applies.
- Special cases, which skip CALC:
  - Divide by zero (`SrcB`=0, Funct3[2]=1): quotient = 0xFFFFFFFF, remainder = `SrcA`.
  - Signed overflow (DIV/REM, `SrcA`=0x80000000, `SrcB`=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC:
  - Operands are converted to magnitudes according to signedness. MULHSU treats only `SrcA` as signed; DIVU, REMU and MULHU treat both as unsigned.
  - Each cycle performs one iteration on the 64-bit product or remainder:quotient register.
  - The counter increments each cycle; CALC moves to FIX when the counter reaches 31, giving exactly 32 iterations.
- FIX:
  - Applies two's-complement negation to the result when the result sign is negative.
  - For DIV the quotient sign is sign(A) XOR sign(B). For REM the remainder takes the sign of the dividend.
  - Selects the output: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Registers the selected value into `Result`, then moves to DONE.
- DONE: moves to IDLE unconditionally.
- `Start` outside IDLE (including in DONE) is ignored; the operation is not queued.
- `Result` holds its value until the next FIX.

## Timing
- Reset values: state = IDLE, `Busy`=0, `Done`=0, `Result`=0, counter = 0, working register = 0.
- Let E0 be the edge that samples `Start`.
- Normal path:
  - CALC covers edges E1..E32.
  - FIX occurs at E33.
  - `Done` is high between E33 and E34.
  - Latency is 34 cycles from E0 to IDLE.
- Special path:
  - FIX occurs at E1.
  - `Done` is high between E1 and E2.
- `Result` is valid in the `Done` cycle. The controller asserts `RegWrite` in that same cycle.
- `Busy` and `Done` are never both high.
- Earliest back-to-back `Start` is the cycle after `Done`.
- `rst_n` low mid-operation returns all state to the reset values immediately, without waiting for a clock edge. No `Done` is produced for the aborted operation.
- All arithmetic is modulo 2^64 internally and truncated to XLEN at the output.

## Structure
- Shared package `riscv_pkg` holds:
  - `muldiv_op_e`, the 3-bit enum matching Funct3.
  - `muldiv_state_e` with values IDLE, CALC, FIX, DONE.
  - `XLEN`.
  - The constants for the special-case quotient values.
- Single module; no sub-module is needed. The shared shift/add-subtract datapath and the FSM stay in `muldiv_unit`.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (-3), Start at E0: `Busy` is high E1..E33; `Done` is high only after E33; `Result`=0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide and remainder, A=0xFFFFFFF9 (-7), B=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - Inputs are changed after E0 to confirm they are ignored.
- Divide by zero, A=5, B=0:
  - DIVU → 0xFFFFFFFF, REMU → 5.
  - `Done` is high after E1, with no CALC cycles.
- Overflow, A=0x80000000, B=0xFFFFFFFF:
  - DIV → 0x80000000, REM → 0.
  - Fast path, same timing as divide by zero.
- Control behaviour:
  - `Start` held high during CALC is ignored.
  - Drive `rst_n` low mid-CALC (e.g. at E10 plus half a cycle): `Busy`, `Done` and `Result` read 0 immediately.
  - After release, a new MUL 3×4 returns 12 with full timing.
